// File: rtl/dz_intr_pkg.sv
// Shared types and the priority comparison for the DZ-class interrupt controller.
package dz_intr_pkg;

   typedef enum logic [1:0] {S_IDLE, S_ACT, S_WAIT, S_DONE} src_state_t;
   typedef enum logic [1:0] {A_IDLE, A_SAMPLE, A_HOLD, A_CLEAR} arb_state_t;

   localparam int MAX_SRC = 16;

   // Rank key {wrapped, index}: in rotation mode, indices below the pointer
   // rank after all indices at or above it, which gives the circular order.
   function automatic logic prio_higher(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] ptr, input logic rrmode);
      logic [4:0] ka;
      logic [4:0] kb;
      ka = {rrmode && (a < ptr), a};
      kb = {rrmode && (b < ptr), b};
      return ka < kb;
   endfunction

endpackage

// File: rtl/dz_intr_src.sv
// One interrupt source: request, wait for service, then wait for the done strobe to drop.
module dz_intr_src
   import dz_intr_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic ie,
   input  logic set,
   input  logic done,
   input  logic grant_clr,
   output logic intr,
   output logic act
);

   src_state_t state, state_nxt;

   always_ff @(posedge clk) begin
      if (rst || clr) state <= S_IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (set && ie) state_nxt = S_ACT;
         S_ACT:  if (grant_clr) state_nxt = S_WAIT;
         S_WAIT: if (done)      state_nxt = S_DONE;
         S_DONE: if (!done)     state_nxt = S_IDLE;
         default:               state_nxt = S_IDLE;
      endcase
   end

   // Dropping ie only masks the request; the source stays active.
   assign act  = (state == S_ACT);
   assign intr = act && ie;

endmodule

// File: rtl/dz_intr_arb.sv
// Multi-source interrupt controller: per-source FSMs plus a vector-cycle arbiter
// that commits one source index per iack, fixed or round-robin priority.
module dz_intr_arb
   import dz_intr_pkg::*;
#(
   parameter  int NSRC   = 2,
   parameter  int RRMODE = 0,
   localparam int IDXW   = $clog2(NSRC > 1 ? NSRC : 2)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            iack,
   input  logic [NSRC-1:0] src_ie,
   input  logic [NSRC-1:0] src_set,
   input  logic [NSRC-1:0] src_done,
   output logic [NSRC-1:0] src_intr,
   output logic            intr,
   output logic [IDXW-1:0] vect_idx,
   output logic            vect_valid
);

   logic [NSRC-1:0] grant_clr;
   logic [NSRC-1:0] act;
   logic [IDXW-1:0] rr_ptr;

   arb_state_t arb_st, arb_nxt;

   logic [3:0] win;
   logic       found;
   logic       upgrade;
   logic [3:0] ptr4;

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      dz_intr_src u_src (
         .clk       (clk),
         .rst       (rst),
         .clr       (clr),
         .ie        (src_ie[i]),
         .set       (src_set[i]),
         .done      (src_done[i]),
         .grant_clr (grant_clr[i]),
         .intr      (src_intr[i]),
         .act       (act[i])
      );
   end

   assign intr = |src_intr;
   assign ptr4 = 4'(rr_ptr);

   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (src_intr[i] && (!found || prio_higher(4'(i), win, ptr4, RRMODE != 0))) begin
            win   = 4'(i);
            found = 1'b1;
         end
      end
      upgrade = found && prio_higher(win, 4'(vect_idx), ptr4, RRMODE != 0);
   end

   always_ff @(posedge clk) begin
      if (rst || clr) arb_st <= A_IDLE;
      else            arb_st <= arb_nxt;
   end

   always_comb begin
      arb_nxt   = arb_st;
      grant_clr = '0;
      case (arb_st)
         A_IDLE:   if (|act) arb_nxt = A_SAMPLE;
         A_SAMPLE: if (iack) arb_nxt = A_HOLD;
         A_HOLD:   if (!iack) arb_nxt = A_CLEAR;
         A_CLEAR: begin
            arb_nxt = A_IDLE;
            for (int i = 0; i < NSRC; i++)
               grant_clr[i] = vect_valid && (vect_idx == IDXW'(i));
         end
         default:  arb_nxt = A_IDLE;
      endcase
   end

   // vect_idx survives into A_IDLE for the vector generator; only valid drops.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         vect_idx   <= '0;
         vect_valid <= 1'b0;
         rr_ptr     <= '0;
      end else begin
         case (arb_st)
            A_IDLE: vect_valid <= 1'b0;
            A_SAMPLE: begin
               if (found && !vect_valid) begin
                  vect_idx   <= IDXW'(win);
                  vect_valid <= 1'b1;
               end else if (vect_valid && upgrade) begin
                  vect_idx <= IDXW'(win);
               end
            end
            A_CLEAR: if (RRMODE != 0) rr_ptr <= IDXW'((int'(vect_idx) + 1) % NSRC);
            default: ;
         endcase
      end
   end

endmodule
